rf_port_arbiter: RTL and testbench

- Shares the single-port register file (one address, one write enable, combinational read) between two requesters.
- Requesters use a valid/ready handshake. The block picks one request per cycle by round-robin, registers it into a one-entry command stage, and drives the file port from that stage.
- Read data returns on a per-requester one-cycle response pulse.
- A built-in clear sequencer walks every address and writes zero. It runs on request and, optionally, out of reset.

---
 rtl/rf_arb_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 32 +++
 rtl/rf_port_arbiter.sv | 137 +++++++++++++
 tb/tb_rf_port_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file port arbiter.
package rf_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int CMD_W   = 8;
    localparam int CMD_D   = 4;

    typedef enum logic {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

    // One-entry command stage contents at the default widths.
    typedef struct packed {
        logic             valid;
        logic             src;
        logic             we;
        logic [CMD_D-1:0] addr;
        logic [CMD_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker; rr_last remembers the most recent winner.
module rr_arbiter2 (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic rr_last_reg;

    // A lone requester always wins; on contention the one that did not win last time goes.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_last_reg ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember the winner only when its request was actually taken.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            rr_last_reg <= 1'b0;
        end else if (advance) begin
            rr_last_reg <= grant[1];
        end
    end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares a single-port register file between two requesters through a
// one-entry command stage, with a built-in whole-file clear sequencer.
module rf_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int W              = CMD_W,
    parameter int D              = CMD_D,
    parameter bit CLEAR_ON_RESET = 1'b0
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_we,
    input  logic [NUM_REQ*D-1:0] req_addr,
    input  logic [NUM_REQ*W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   resp_valid,
    output logic [W-1:0]         resp_rdata,
    input  logic                 clear_start,
    output logic                 clear_busy,
    output logic                 clear_done,
    output logic                 rf_write_en,
    output logic [D-1:0]         rf_addr,
    output logic [W-1:0]         rf_data_in,
    input  logic [W-1:0]         rf_data_out
);

    localparam arb_state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : SERVE;

    arb_state_t         state_reg;
    logic [D-1:0]       clr_cnt_reg;
    logic               cmd_valid_reg;
    logic               cmd_src_reg;
    logic               cmd_we_reg;
    logic [D-1:0]       cmd_addr_reg;
    logic [W-1:0]       cmd_wdata_reg;
    logic [NUM_REQ-1:0] resp_valid_reg;
    logic [W-1:0]       resp_rdata_reg;
    logic               clear_done_reg;

    logic [NUM_REQ-1:0] grant;
    logic               serve_open;
    logic               accept;
    logic               win;
    logic               clr_last;
    logic [D-1:0]       addr_arr  [NUM_REQ];
    logic [W-1:0]       wdata_arr [NUM_REQ];

    // Requests are only taken in SERVE and never in the cycle a clear is being asked for.
    assign serve_open = (state_reg == SERVE) && !clear_start;
    assign accept     = |(req_valid & req_ready);
    assign win        = grant[1];
    assign clr_last   = (clr_cnt_reg == {D{1'b1}});

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi]  = req_addr[gi*D +: D];
            assign wdata_arr[gi] = req_wdata[gi*W +: W];
            assign req_ready[gi] = grant[gi] & serve_open;
        end
    endgenerate

    rr_arbiter2 u_rr (
        .CLK     (CLK),
        .Reset   (Reset),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    // Sequencer state, command stage and read-response registers.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_reg      <= RESET_STATE;
            clr_cnt_reg    <= '0;
            cmd_valid_reg  <= 1'b0;
            cmd_src_reg    <= 1'b0;
            cmd_we_reg     <= 1'b0;
            cmd_addr_reg   <= '0;
            cmd_wdata_reg  <= '0;
            resp_valid_reg <= '0;
            resp_rdata_reg <= '0;
            clear_done_reg <= 1'b0;
        end else begin
            resp_valid_reg <= '0;
            clear_done_reg <= 1'b0;
            // The command executing now is a read: capture its data at this edge.
            if (cmd_valid_reg && !cmd_we_reg) begin
                resp_rdata_reg              <= rf_data_out;
                resp_valid_reg[cmd_src_reg] <= 1'b1;
            end
            case (state_reg)
                SERVE: begin
                    if (clear_start) begin
                        state_reg     <= CLEAR;
                        clr_cnt_reg   <= '0;
                        cmd_valid_reg <= 1'b0;
                    end else if (accept) begin
                        cmd_valid_reg <= 1'b1;
                        cmd_src_reg   <= win;
                        cmd_we_reg    <= req_we[win];
                        cmd_addr_reg  <= addr_arr[win];
                        cmd_wdata_reg <= wdata_arr[win];
                    end else begin
                        cmd_valid_reg <= 1'b0;
                    end
                end
                CLEAR: begin
                    clr_cnt_reg <= clr_cnt_reg + D'(1);
                    if (clr_last) begin
                        state_reg      <= SERVE;
                        clear_done_reg <= 1'b1;
                    end
                end
                default: state_reg <= SERVE;
            endcase
        end
    end

    // File port: the clear sweep owns it in CLEAR, otherwise the command stage does.
    always_comb begin
        rf_addr     = cmd_addr_reg;
        rf_data_in  = cmd_wdata_reg;
        rf_write_en = cmd_valid_reg & cmd_we_reg & ~Reset;
        if (state_reg == CLEAR) begin
            rf_addr     = clr_cnt_reg;
            rf_data_in  = '0;
            rf_write_en = ~Reset;
        end
    end

    assign clear_busy = (state_reg == CLEAR);
    assign clear_done = clear_done_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter with a behavioural register file.
module tb_rf_port_arbiter;

    logic        CLK;
    logic        Reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [7:0]  resp_rdata;
    logic        clear_start;
    logic        clear_busy;
    logic        clear_done;
    logic        rf_write_en;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_data_in;
    logic [7:0]  rf_data_out;
    logic [7:0]  rf_mem [16];

    // Second instance that clears itself out of reset.
    logic [1:0]  req_valid_c;
    logic [1:0]  req_we_c;
    logic [7:0]  req_addr_c;
    logic [15:0] req_wdata_c;
    logic [1:0]  req_ready_c;
    logic [1:0]  resp_valid_c;
    logic [7:0]  resp_rdata_c;
    logic        clear_start_c;
    logic        clear_busy_c;
    logic        clear_done_c;
    logic        rf_write_en_c;
    logic [3:0]  rf_addr_c;
    logic [7:0]  rf_data_in_c;
    logic [7:0]  rf_data_out_c;

    int checks   = 0;
    int failures = 0;

    assign req_valid_c   = 2'b01;
    assign req_we_c      = 2'b00;
    assign req_addr_c    = 8'h00;
    assign req_wdata_c   = 16'h0000;
    assign clear_start_c = 1'b0;
    assign rf_data_out_c = 8'h00;

    rf_port_arbiter #(.W(8), .D(4), .CLEAR_ON_RESET(1'b0)) dut (
        .CLK(CLK), .Reset(Reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .rf_write_en(rf_write_en), .rf_addr(rf_addr), .rf_data_in(rf_data_in),
        .rf_data_out(rf_data_out)
    );

    rf_port_arbiter #(.W(8), .D(4), .CLEAR_ON_RESET(1'b1)) dut_c (
        .CLK(CLK), .Reset(Reset),
        .req_valid(req_valid_c), .req_we(req_we_c), .req_addr(req_addr_c), .req_wdata(req_wdata_c),
        .req_ready(req_ready_c), .resp_valid(resp_valid_c), .resp_rdata(resp_rdata_c),
        .clear_start(clear_start_c), .clear_busy(clear_busy_c), .clear_done(clear_done_c),
        .rf_write_en(rf_write_en_c), .rf_addr(rf_addr_c), .rf_data_in(rf_data_in_c),
        .rf_data_out(rf_data_out_c)
    );

    // Register file model: combinational read, write on the rising edge.
    assign rf_data_out = rf_mem[rf_addr];
    always @(posedge CLK) begin
        if (rf_write_en) rf_mem[rf_addr] <= rf_data_in;
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [3:0] a, input logic [7:0] d);
        req_valid[i]       = v;
        req_we[i]          = we;
        req_addr[i*4 +: 4] = a;
        req_wdata[i*8 +: 8] = d;
    endtask

    initial begin
        Reset = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; clear_start = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_rdata", 32'(resp_rdata), 32'h0);
        chk("rst_busy", 32'(clear_busy), 32'h0);
        chk("rst_done", 32'(clear_done), 32'h0);
        chk("rst_we", 32'(rf_write_en), 32'h0);
        chk("c_rst_we", 32'(rf_write_en_c), 32'h0);
        chk("c_rst_busy", 32'(clear_busy_c), 32'h1);
        chk("c_rst_ready", 32'(req_ready_c), 32'h0);

        // Self-clearing instance sweeps 0..15 after release.
        Reset = 1'b0; #1;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin @(negedge CLK); #1; end
            chk("c_clr_we", 32'(rf_write_en_c), 32'h1);
            chk("c_clr_addr", 32'(rf_addr_c), 32'(k));
            chk("c_clr_din", 32'(rf_data_in_c), 32'h0);
            chk("c_clr_ready", 32'(req_ready_c), 32'h0);
        end
        @(negedge CLK); #1;
        chk("c_done", 32'(clear_done_c), 32'h1);
        chk("c_busy_end", 32'(clear_busy_c), 32'h0);
        chk("c_ready_end", 32'(req_ready_c), 32'h1);
        @(negedge CLK); #1;
        chk("c_done_pulse", 32'(clear_done_c), 32'h0);
        @(negedge CLK); #1;
        chk("c_resp_valid", 32'(resp_valid_c), 32'h1);
        chk("c_resp_rdata", 32'(resp_rdata_c), 32'h0);

        // Write then read addr 3.
        @(negedge CLK); set_req(0, 1'b1, 1'b1, 4'd3, 8'hA5); #1;
        chk("wr_ready", 32'(req_ready), 32'h1);
        @(negedge CLK); #1;
        chk("wr_we", 32'(rf_write_en), 32'h1);
        chk("wr_addr", 32'(rf_addr), 32'h3);
        chk("wr_din", 32'(rf_data_in), 32'hA5);
        set_req(0, 1'b1, 1'b0, 4'd3, 8'h00); #1;
        chk("rd_ready", 32'(req_ready), 32'h1);
        @(negedge CLK); set_req(0, 1'b0, 1'b0, 4'd0, 8'h00); #1;
        chk("rd_exec_we", 32'(rf_write_en), 32'h0);
        chk("rd_no_resp_yet", 32'(resp_valid), 32'h0);
        @(negedge CLK); #1;
        chk("rd_resp_valid", 32'(resp_valid), 32'h1);
        chk("rd_resp_rdata", 32'(resp_rdata), 32'hA5);
        @(negedge CLK); #1;
        chk("rd_resp_pulse", 32'(resp_valid), 32'h0);
        chk("rd_rdata_hold", 32'(resp_rdata), 32'hA5);

        // Preload addr 1 and 2, then contend with both requesters reading.
        @(negedge CLK); set_req(0, 1'b1, 1'b1, 4'd1, 8'h5A);
        @(negedge CLK); set_req(0, 1'b1, 1'b1, 4'd2, 8'hC3);
        @(negedge CLK); set_req(0, 1'b0, 1'b0, 4'd0, 8'h00);
        @(negedge CLK);
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (k < 4) begin
                set_req(0, 1'b1, 1'b0, 4'd1, 8'h00);
                set_req(1, 1'b1, 1'b0, 4'd2, 8'h00);
            end else begin
                req_valid = 2'b00;
            end
            #1;
            if (k < 4) chk("cont_ready", 32'(req_ready), (k % 2 == 0) ? 32'h2 : 32'h1);
            if (k >= 2) begin
                chk("cont_resp_valid", 32'(resp_valid), (k % 2 == 0) ? 32'h2 : 32'h1);
                chk("cont_resp_rdata", 32'(resp_rdata), (k % 2 == 0) ? 32'hC3 : 32'h5A);
            end
        end

        // Write by req1 immediately followed by read of the same address by req0.
        @(negedge CLK); set_req(1, 1'b1, 1'b1, 4'd7, 8'h3C); #1;
        chk("haz_wr_ready", 32'(req_ready), 32'h2);
        @(negedge CLK); set_req(1, 1'b0, 1'b0, 4'd0, 8'h00); set_req(0, 1'b1, 1'b0, 4'd7, 8'h00); #1;
        chk("haz_rd_ready", 32'(req_ready), 32'h1);
        chk("haz_wr_we", 32'(rf_write_en), 32'h1);
        @(negedge CLK); set_req(0, 1'b0, 1'b0, 4'd0, 8'h00);
        @(negedge CLK); #1;
        chk("haz_resp_valid", 32'(resp_valid), 32'h1);
        chk("haz_resp_rdata", 32'(resp_rdata), 32'h3C);

        // Clear sweep with nonzero data at both ends of the file.
        @(negedge CLK); set_req(0, 1'b1, 1'b1, 4'd0, 8'h11);
        @(negedge CLK); set_req(0, 1'b1, 1'b1, 4'd15, 8'hFF);
        @(negedge CLK); set_req(0, 1'b1, 1'b0, 4'd0, 8'h00); clear_start = 1'b1; #1;
        chk("clr_gate_ready", 32'(req_ready), 32'h0);
        chk("clr_inflight_we", 32'(rf_write_en), 32'h1);
        chk("clr_inflight_addr", 32'(rf_addr), 32'hF);
        for (int k = 0; k < 16; k++) begin
            @(negedge CLK); clear_start = 1'b0; #1;
            chk("clr_busy", 32'(clear_busy), 32'h1);
            chk("clr_ready", 32'(req_ready), 32'h0);
            chk("clr_we", 32'(rf_write_en), 32'h1);
            chk("clr_addr", 32'(rf_addr), 32'(k));
            chk("clr_din", 32'(rf_data_in), 32'h0);
            chk("clr_done_early", 32'(clear_done), 32'h0);
        end
        @(negedge CLK); #1;
        chk("clr_busy_end", 32'(clear_busy), 32'h0);
        chk("clr_done", 32'(clear_done), 32'h1);
        chk("clr_ready_back", 32'(req_ready), 32'h1);
        @(negedge CLK); set_req(0, 1'b1, 1'b0, 4'd15, 8'h00); #1;
        chk("clr_done_pulse", 32'(clear_done), 32'h0);
        @(negedge CLK); set_req(0, 1'b0, 1'b0, 4'd0, 8'h00); #1;
        chk("clr_rd0_valid", 32'(resp_valid), 32'h1);
        chk("clr_rd0_rdata", 32'(resp_rdata), 32'h0);
        @(negedge CLK); #1;
        chk("clr_rd15_valid", 32'(resp_valid), 32'h1);
        chk("clr_rd15_rdata", 32'(resp_rdata), 32'h0);

        // Reset in the middle of a clear; addr 9 lies beyond the partial sweep.
        @(negedge CLK); set_req(0, 1'b1, 1'b1, 4'd9, 8'h99);
        @(negedge CLK); set_req(0, 1'b0, 1'b0, 4'd0, 8'h00); clear_start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK); clear_start = 1'b0; #1;
            chk("mid_addr", 32'(rf_addr), 32'(k));
        end
        chk("mid_busy", 32'(clear_busy), 32'h1);
        Reset = 1'b1; #1;
        chk("mid_rst_busy", 32'(clear_busy), 32'h0);
        chk("mid_rst_done", 32'(clear_done), 32'h0);
        chk("mid_rst_resp", 32'(resp_valid), 32'h0);
        chk("mid_rst_we", 32'(rf_write_en), 32'h0);
        @(negedge CLK); Reset = 1'b0; set_req(0, 1'b1, 1'b0, 4'd3, 8'h00); #1;
        chk("post_rst_ready3", 32'(req_ready), 32'h1);
        chk("post_rst_busy", 32'(clear_busy), 32'h0);
        @(negedge CLK); set_req(0, 1'b1, 1'b0, 4'd9, 8'h00); #1;
        chk("post_rst_ready9", 32'(req_ready), 32'h1);
        @(negedge CLK); set_req(0, 1'b0, 1'b0, 4'd0, 8'h00); #1;
        chk("post_rst_rd3_valid", 32'(resp_valid), 32'h1);
        chk("post_rst_rd3_rdata", 32'(resp_rdata), 32'h0);
        @(negedge CLK); #1;
        chk("post_rst_rd9_valid", 32'(resp_valid), 32'h1);
        chk("post_rst_rd9_rdata", 32'(resp_rdata), 32'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
